// File: rtl/prio_pkg.sv
// prio_pkg: shared widths, FSM state type and index-to-one-hot helper
// for the priority encoder/decoder pair.
package prio_pkg;
    localparam int IDX_W = 3;
    localparam int VEC_W = 2 ** IDX_W;

    typedef enum logic {ACCUM, HOLD} state_t;

    function automatic logic [VEC_W-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
        return VEC_W'(1) << idx;
    endfunction
endpackage

// File: rtl/deco_3x8.sv
// deco_3x8: combinational index to one-hot decoder; en=0 yields zero.
module deco_3x8
    import prio_pkg::*;
(
    input  logic             en,
    input  logic [IDX_W-1:0] idx,
    output logic [VEC_W-1:0] onehot
);
    assign onehot = en ? idx2onehot(idx) : '0;
endmodule

// File: rtl/prio_deco_3x8_acc.sv
// prio_deco_3x8_acc: rebuilds request vectors from a highest-first index
// stream and flags frames that break ordering or empty-beat rules.
module prio_deco_3x8_acc
    import prio_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] d_in,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic             in_empty,
    output logic             in_ready,
    output logic [VEC_W-1:0] d_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err
);
    state_t           state;
    logic [VEC_W-1:0] acc;
    logic [VEC_W-1:0] bit_v;
    logic [IDX_W-1:0] last_idx;
    logic             first;
    logic             err_acc;
    logic             accept;
    logic             beat_err;

    deco_3x8 u_deco (
        .en     (!in_empty),
        .idx    (d_in),
        .onehot (bit_v)
    );

    // in_ready is gated by rst_n so it reads 0 for the whole reset window
    assign in_ready  = rst_n && state == ACCUM;
    assign out_valid = state == HOLD;
    assign accept    = in_valid && in_ready;
    assign beat_err  = in_empty ? (!first || !in_last) : (!first && d_in >= last_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ACCUM;
            acc      <= '0;
            d_out    <= '0;
            last_idx <= '0;
            first    <= 1'b1;
            err_acc  <= 1'b0;
            err      <= 1'b0;
        end else if (state == ACCUM) begin
            if (accept && in_last) begin
                d_out    <= acc | bit_v;
                err      <= err_acc | beat_err;
                state    <= HOLD;
                acc      <= '0;
                err_acc  <= 1'b0;
                last_idx <= '0;
                first    <= 1'b1;
            end else if (accept) begin
                acc     <= acc | bit_v;
                err_acc <= err_acc | beat_err;
                first   <= 1'b0;
                if (!in_empty) last_idx <= d_in;
            end
        end else if (out_ready) begin
            state <= ACCUM;
        end
    end
endmodule

// File: tb/tb_prio_deco_3x8_acc.sv
// tb_prio_deco_3x8_acc: directed plus randomized frames checked against a
// frame-level model of the rebuilt vector and the ordering/empty rules.
module tb_prio_deco_3x8_acc;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] d_in;
    logic       in_valid;
    logic       in_last;
    logic       in_empty;
    logic       in_ready;
    logic [7:0] d_out;
    logic       out_valid;
    logic       out_ready;
    logic       err;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit empty;
        int idx;
    } beat_t;

    beat_t beats[$];

    prio_deco_3x8_acc dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .d_in      (d_in),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_empty  (in_empty),
        .in_ready  (in_ready),
        .d_out     (d_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Vector is the set of all non-empty indices; an error is any empty beat
    // in a multi-beat frame or any non-empty index not below its predecessor.
    function automatic void model(output logic [7:0] v, output logic e);
        int prev = -1;
        v = '0;
        e = 1'b0;
        foreach (beats[i]) begin
            if (beats[i].empty) begin
                if (beats.size() > 1) e = 1'b1;
            end else begin
                v[beats[i].idx] = 1'b1;
                if (prev >= 0 && beats[i].idx >= prev) e = 1'b1;
                prev = beats[i].idx;
            end
        end
    endfunction

    task automatic add(input int idx);
        beat_t b;
        b.empty = 1'b0;
        b.idx   = idx;
        beats.push_back(b);
    endtask

    task automatic add_empty();
        beat_t b;
        b.empty = 1'b1;
        b.idx   = $urandom_range(0, 7);
        beats.push_back(b);
    endtask

    // Called at a negedge; returns at the negedge after the beat is accepted.
    task automatic send(input beat_t b, input bit last);
        int t = 0;
        d_in     = b.idx[2:0];
        in_empty = b.empty;
        in_last  = last;
        in_valid = 1'b1;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("in_ready_timeout", {31'b0, in_ready}, 1);
        check("ov_accum", {31'b0, out_valid}, 0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_frame(input int hold);
        logic [7:0] ev;
        logic       ee;
        model(ev, ee);
        out_ready = (hold == 0);
        foreach (beats[i]) send(beats[i], i == beats.size() - 1);
        check("out_valid", {31'b0, out_valid}, 1);
        check("in_ready_hold", {31'b0, in_ready}, 0);
        check("d_out", {24'b0, d_out}, {24'b0, ev});
        check("err", {31'b0, err}, {31'b0, ee});
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            d_in     = 3'd7;
            in_last  = 1'b1;
            in_empty = 1'b0;
            @(negedge clk);
            check("bp_valid", {31'b0, out_valid}, 1);
            check("bp_ready", {31'b0, in_ready}, 0);
            check("bp_d_out", {24'b0, d_out}, {24'b0, ev});
            check("bp_err", {31'b0, err}, {31'b0, ee});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("release_valid", {31'b0, out_valid}, 0);
        check("release_ready", {31'b0, in_ready}, 1);
        beats.delete();
    endtask

    initial begin
        rst_n     = 1'b1;
        d_in      = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_empty  = 1'b0;
        out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_d_out", {24'b0, d_out}, 0);
        check("rst_valid", {31'b0, out_valid}, 0);
        check("rst_err", {31'b0, err}, 0);
        check("rst_ready", {31'b0, in_ready}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        add(7);       do_frame(0);
        add(0);       do_frame(0);
        add_empty();  do_frame(0);
        add(7); add(6); add(3); add(2); do_frame(0);
        add(5); add(4); add(1); add(0); do_frame(5);
        add(2); add(5); do_frame(0);
        add(4); add(4); do_frame(0);
        add(3);       do_frame(0);
        add(6); add_empty(); do_frame(0);

        // Reset mid-frame while d_out still holds the previous frame's vector
        add(7); add(6);
        send(beats[0], 1'b0);
        send(beats[1], 1'b0);
        beats.delete();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_d_out", {24'b0, d_out}, 0);
        check("midrst_err", {31'b0, err}, 0);
        check("midrst_ready", {31'b0, in_ready}, 0);
        check("midrst_valid", {31'b0, out_valid}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        add(1);       do_frame(0);

        for (int f = 0; f < 60; f++) begin
            int kind = $urandom_range(0, 9);
            if (kind == 0) begin
                add_empty();
            end else if (kind < 7) begin
                int prev = $urandom_range(0, 7);
                add(prev);
                while (prev > 0 && $urandom_range(0, 3) != 0) begin
                    prev = $urandom_range(0, prev - 1);
                    add(prev);
                end
            end else begin
                int n = $urandom_range(1, 9);
                for (int i = 0; i < n; i++) begin
                    if ($urandom_range(0, 7) == 0) add_empty();
                    else add($urandom_range(0, 7));
                end
            end
            do_frame($urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
